// File: rtl/key_array_ctrl_if.sv
// Bundle of the raw key pins and the per-key debounced level/event outputs.
// The slave side is the key front end; the master side is whoever drives the
// pins and consumes the events (menu logic, or a bench).
interface key_array_ctrl_if #(
    parameter int N_KEYS = 4
);
    logic [N_KEYS-1:0] key;
    logic [N_KEYS-1:0] key_level;
    logic [N_KEYS-1:0] key_press;
    logic [N_KEYS-1:0] key_release;
    logic [N_KEYS-1:0] key_long;
    logic [N_KEYS-1:0] key_repeat;

    modport master (
        output key,
        input  key_level,
        input  key_press,
        input  key_release,
        input  key_long,
        input  key_repeat
    );

    modport slave (
        input  key,
        output key_level,
        output key_press,
        output key_release,
        output key_long,
        output key_repeat
    );
endinterface

// File: rtl/key_array_ctrl.sv
// Multi-channel key front end. Every channel has a 2-flop synchroniser, a
// mismatch-counting debouncer and an IDLE/HELD/LONG press tracker that emits
// single-cycle press, release, long-press and auto-repeat pulses. Channels are
// identical and fully independent; bit i of every output belongs to key[i].
module key_array_ctrl #(
    parameter int N_KEYS        = 4,
    parameter int ACTIVE_LOW    = 1,
    parameter int DEB_CYCLES    = 524288,
    parameter int LONG_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 10000000
) (
    input  logic            clk,
    input  logic            rst,
    key_array_ctrl_if.slave bus
);

    // Debounce counter only has to reach DEB_CYCLES-1.
    localparam int DEB_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    // Hold counter serves both the long-press and the repeat interval, so it
    // is sized for whichever of the two is larger.
    localparam int HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int HOLD_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

    localparam logic [DEB_W-1:0]  DEB_LAST    = DEB_W'(DEB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] LONG_LAST   = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] REPEAT_LAST = HOLD_W'((REPEAT_CYCLES > 0) ? (REPEAT_CYCLES - 1) : 0);
    localparam logic              REPEAT_EN   = (REPEAT_CYCLES > 0);

    // XOR mask turning the raw pin into "1 = pressed".
    localparam logic              POL_INV     = (ACTIVE_LOW != 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HELD = 2'd1,
        ST_LONG = 2'd2
    } key_state_e;

    logic [N_KEYS-1:0] level_vec;
    logic [N_KEYS-1:0] press_vec;
    logic [N_KEYS-1:0] release_vec;
    logic [N_KEYS-1:0] long_vec;
    logic [N_KEYS-1:0] repeat_vec;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key

        logic              sync1_d, sync1_q;
        logic              sync2_d, sync2_q;
        logic              level_d, level_q;
        logic [DEB_W-1:0]  deb_cnt_d, deb_cnt_q;
        logic              accept;
        logic              press_evt;
        logic              release_evt;

        key_state_e        state_d, state_q;
        logic [HOLD_W-1:0] hold_d, hold_q;
        logic              press_d, press_q;
        logic              release_d, release_q;
        logic              long_d, long_q;
        logic              repeat_d, repeat_q;

        // Normalise polarity and shift the pin through the two synchroniser stages.
        always_comb begin
            sync1_d = bus.key[i] ^ POL_INV;
            sync2_d = sync1_q;
        end

        // Accept a new level only after DEB_CYCLES consecutive mismatching cycles; any agreement restarts the count.
        always_comb begin
            level_d     = level_q;
            deb_cnt_d   = '0;
            accept      = 1'b0;
            press_evt   = 1'b0;
            release_evt = 1'b0;
            if (sync2_q != level_q) begin
                if (deb_cnt_q == DEB_LAST) begin
                    accept  = 1'b1;
                    level_d = sync2_q;
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
            press_evt   = accept &  sync2_q;
            release_evt = accept & ~sync2_q;
        end

        // Press tracker: a release always wins over a long/repeat threshold landing on the same cycle.
        always_comb begin
            state_d   = state_q;
            hold_d    = hold_q;
            press_d   = press_evt;
            release_d = release_evt;
            long_d    = 1'b0;
            repeat_d  = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    hold_d = '0;
                    if (press_evt) begin
                        state_d = ST_HELD;
                    end
                end
                ST_HELD: begin
                    if (release_evt) begin
                        state_d = ST_IDLE;
                        hold_d  = '0;
                    end else if (hold_q == LONG_LAST) begin
                        state_d = ST_LONG;
                        long_d  = 1'b1;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                ST_LONG: begin
                    if (release_evt) begin
                        state_d = ST_IDLE;
                        hold_d  = '0;
                    end else if (!REPEAT_EN) begin
                        hold_d = '0;
                    end else if (hold_q == REPEAT_LAST) begin
                        repeat_d = 1'b1;
                        hold_d   = '0;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    hold_d  = '0;
                end
            endcase
        end

        // All channel state; reset loads the released level and parks the tracker in IDLE.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync1_q   <= 1'b0;
                sync2_q   <= 1'b0;
                level_q   <= 1'b0;
                deb_cnt_q <= '0;
                state_q   <= ST_IDLE;
                hold_q    <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
                repeat_q  <= 1'b0;
            end else begin
                sync1_q   <= sync1_d;
                sync2_q   <= sync2_d;
                level_q   <= level_d;
                deb_cnt_q <= deb_cnt_d;
                state_q   <= state_d;
                hold_q    <= hold_d;
                press_q   <= press_d;
                release_q <= release_d;
                long_q    <= long_d;
                repeat_q  <= repeat_d;
            end
        end

        assign level_vec[i]   = level_q;
        assign press_vec[i]   = press_q;
        assign release_vec[i] = release_q;
        assign long_vec[i]    = long_q;
        assign repeat_vec[i]  = repeat_q;
    end

    assign bus.key_level   = level_vec;
    assign bus.key_press   = press_vec;
    assign bus.key_release = release_vec;
    assign bus.key_long    = long_vec;
    assign bus.key_repeat  = repeat_vec;

endmodule

// File: tb/tb_key_array_ctrl.sv
// Bench for key_array_ctrl: two instances (REPEAT_CYCLES=8 and =0) share the
// same key pins and are compared every cycle against a timeline model that
// reasons in "cycles of mismatch" and "cycles since press" rather than states.
module tb_key_array_ctrl;

   localparam int NK   = 4;
   localparam int DEB  = 4;
   localparam int LONG = 20;
   localparam int REP  = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [NK-1:0] key = '1;

   int checks   = 0;
   int failures = 0;

   // Model state per key: two-stage delay, accepted level, mismatch run, cycles since press
   int m_d1    [NK];
   int m_d2    [NK];
   int m_lvl   [NK];
   int m_run   [NK];
   int m_since [NK];

   logic [NK-1:0] e_level, e_press, e_release, e_long, e_rep8;

   int long_cnt3 = 0;
   int rep0_cnt  = 0;

   key_array_ctrl_if #(.N_KEYS(NK)) bus8 ();
   key_array_ctrl_if #(.N_KEYS(NK)) bus0 ();

   assign bus8.key = key;
   assign bus0.key = key;

   key_array_ctrl #(
      .N_KEYS(NK), .ACTIVE_LOW(1), .DEB_CYCLES(DEB),
      .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP)
   ) dut8 (
      .clk(clk), .rst(rst), .bus(bus8)
   );

   key_array_ctrl #(
      .N_KEYS(NK), .ACTIVE_LOW(1), .DEB_CYCLES(DEB),
      .LONG_CYCLES(LONG), .REPEAT_CYCLES(0)
   ) dut0 (
      .clk(clk), .rst(rst), .bus(bus0)
   );

   // Free-running 10-time-unit clock
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [NK-1:0] obs, input logic [NK-1:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("[TB] FAIL %s at t=%0t: observed=%b expected=%b", tag, $time, obs, expv);
      end
   endtask

   task automatic resetModel();
      for (int i = 0; i < NK; i++) begin
         m_d1[i] = 0; m_d2[i] = 0; m_lvl[i] = 0; m_run[i] = 0; m_since[i] = 0;
      end
      e_level = '0; e_press = '0; e_release = '0; e_long = '0; e_rep8 = '0;
   endtask

   // Advance the model over one rising edge using the pin values present at that edge
   task automatic modelStep();
      if (rst) begin
         resetModel();
         return;
      end
      for (int i = 0; i < NK; i++) begin
         int p;
         bit changed;
         p = (key[i] == 1'b0) ? 1 : 0;
         changed = 1'b0;
         e_press[i] = 1'b0; e_release[i] = 1'b0; e_long[i] = 1'b0; e_rep8[i] = 1'b0;
         if (m_d2[i] != m_lvl[i]) begin
            m_run[i]++;
            if (m_run[i] == DEB) begin
               m_lvl[i] = m_d2[i];
               m_run[i] = 0;
               changed  = 1'b1;
            end
         end else begin
            m_run[i] = 0;
         end
         if (changed && m_lvl[i] == 1) begin
            e_press[i] = 1'b1;
            m_since[i] = 0;
         end else if (changed) begin
            e_release[i] = 1'b1;
         end else if (m_lvl[i] == 1) begin
            m_since[i]++;
            if (m_since[i] == LONG) e_long[i] = 1'b1;
            if (m_since[i] > LONG && ((m_since[i] - LONG) % REP) == 0) e_rep8[i] = 1'b1;
         end
         m_d2[i] = m_d1[i];
         m_d1[i] = p;
         e_level[i] = (m_lvl[i] == 1);
      end
   endtask

   // One clock: model update at the edge, then compare both instances 1 unit later
   task automatic stepCycle();
      @(posedge clk);
      modelStep();
      #1;
      checkOutput("level8",   bus8.key_level,   e_level);
      checkOutput("press8",   bus8.key_press,   e_press);
      checkOutput("release8", bus8.key_release, e_release);
      checkOutput("long8",    bus8.key_long,    e_long);
      checkOutput("repeat8",  bus8.key_repeat,  e_rep8);
      checkOutput("level0",   bus0.key_level,   e_level);
      checkOutput("press0",   bus0.key_press,   e_press);
      checkOutput("release0", bus0.key_release, e_release);
      checkOutput("long0",    bus0.key_long,    e_long);
      checkOutput("repeat0",  bus0.key_repeat,  '0);
      long_cnt3 += int'(bus8.key_long[3]);
      rep0_cnt  += $countones(bus0.key_repeat);
   endtask

   task automatic applyStimulus(input logic [NK-1:0] k, input int cycles);
      key = k;
      for (int c = 0; c < cycles; c++) stepCycle();
   endtask

   initial begin
      int dur [NK];
      logic [NK-1:0] kv;

      resetModel();
      #2 rst = 1'b1;
      stepCycle();
      stepCycle();
      checkOutput("reset_level", bus8.key_level, '0);
      checkOutput("reset_press", bus8.key_press, '0);
      rst = 1'b0;
      applyStimulus(4'hF, 8);

      $display("[TB] clean press on key0");
      applyStimulus(4'b1110, 5);
      checkOutput("clean_no_early_press", bus8.key_press, 4'b0000);
      stepCycle();
      checkOutput("clean_press", bus8.key_press, 4'b0001);
      checkOutput("clean_level", bus8.key_level, 4'b0001);
      stepCycle();
      checkOutput("clean_single_pulse", bus8.key_press, 4'b0000);
      applyStimulus(4'hF, 12);

      $display("[TB] bounce on key1");
      applyStimulus(4'b1101, 3);
      applyStimulus(4'hF, 1);
      applyStimulus(4'b1101, 5);
      checkOutput("bounce_no_event", bus8.key_press, 4'b0000);
      stepCycle();
      checkOutput("bounce_press", bus8.key_press, 4'b0010);
      applyStimulus(4'hF, 12);

      $display("[TB] short press on key2");
      applyStimulus(4'b1011, 10);
      applyStimulus(4'hF, 12);

      $display("[TB] long press with repeat on key3");
      long_cnt3 = 0;
      applyStimulus(4'b0111, 60);
      applyStimulus(4'hF, 12);
      checkOutput("long_once_key3", 4'(long_cnt3), 4'd1);

      $display("[TB] release coincident with long threshold on key0");
      applyStimulus(4'b1110, 20);
      applyStimulus(4'hF, 5);
      stepCycle();
      checkOutput("coincident_release", bus8.key_release, 4'b0001);
      checkOutput("coincident_no_long", bus8.key_long,    4'b0000);
      applyStimulus(4'hF, 8);

      $display("[TB] async reset mid-hold on key0");
      applyStimulus(4'b1110, 15);
      #1 rst = 1'b1;
      resetModel();
      #1;
      checkOutput("async_rst_level",   bus8.key_level,   '0);
      checkOutput("async_rst_press",   bus8.key_press,   '0);
      checkOutput("async_rst_release", bus8.key_release, '0);
      checkOutput("async_rst_long",    bus8.key_long,    '0);
      checkOutput("async_rst_repeat",  bus8.key_repeat,  '0);
      stepCycle();
      stepCycle();
      rst = 1'b0;
      applyStimulus(4'b1110, 5);
      checkOutput("post_rst_no_early", bus8.key_press, 4'b0000);
      stepCycle();
      checkOutput("post_rst_press", bus8.key_press, 4'b0001);
      applyStimulus(4'b1110, 40);
      applyStimulus(4'hF, 12);

      $display("[TB] randomized key activity");
      kv = 4'hF;
      for (int i = 0; i < NK; i++) dur[i] = $urandom_range(1, 20);
      for (int c = 0; c < 800; c++) begin
         for (int i = 0; i < NK; i++) begin
            if (dur[i] == 0) begin
               kv[i]  = ~kv[i];
               dur[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 70);
            end else begin
               dur[i]--;
            end
         end
         applyStimulus(kv, 1);
      end
      applyStimulus(4'hF, 12);

      checkOutput("no_repeat_when_disabled", 4'(rep0_cnt), 4'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
